// File: rtl/mem_wb_skid_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_skid_stage
//  Description : MEM->WB pipeline stage built as a 2-entry skid buffer with a
//                valid/ready handshake. Each entry holds writeback info for
//                one instruction and counts its Tnew down. The final
//                register-file write data is formatted from the head entry:
//                load lane extract/extend, alternate source, or ALU result.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_skid_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int TNEW_W = 2,
    localparam int LSB_W = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_we,
    input  logic [2:0]        in_ld_op,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [LSB_W-1:0]  in_addr_lo,
    input  logic [DATA_W-1:0] in_result,
    input  logic [DATA_W-1:0] in_alt,
    input  logic [TNEW_W-1:0] in_tnew,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_we,
    output logic [DATA_W-1:0] out_wdata,
    output logic [TNEW_W-1:0] out_tnew
);

    localparam logic [2:0] c_OP_NONE = 3'd0;
    localparam logic [2:0] c_OP_LB   = 3'd1;
    localparam logic [2:0] c_OP_LBU  = 3'd2;
    localparam logic [2:0] c_OP_LH   = 3'd3;
    localparam logic [2:0] c_OP_LHU  = 3'd4;
    localparam logic [2:0] c_OP_LW   = 3'd5;
    localparam logic [2:0] c_OP_ALT  = 3'd7;

    // Buffer bookkeeping
    logic [1:0]        r_count;
    logic              r_head;
    logic              r_tail;

    // Entry storage. The data field already holds the selected source
    // (memory word, alternate source or ALU result), so formatting at the
    // output only needs lane extraction.
    logic [31:0]       r_pc   [2];
    logic [REG_AW-1:0] r_rd   [2];
    logic              r_we   [2];
    logic [2:0]        r_op   [2];
    logic [DATA_W-1:0] r_data [2];
    logic [LSB_W-1:0]  r_alo  [2];
    logic [TNEW_W-1:0] r_tnew [2];

    logic              w_push;
    logic              w_pop;
    logic              w_valid;
    logic [DATA_W-1:0] w_src;
    logic [TNEW_W-1:0] w_tnew_cap;

    // in_ready depends on the registered count only, keeping in_valid off
    // any combinational path back to the MEM side.
    assign in_ready   = (r_count != 2'd2);
    assign w_valid    = (r_count != 2'd0);
    assign w_push     = in_valid & in_ready;
    assign w_pop      = w_valid & out_ready;
    assign w_tnew_cap = (in_tnew == '0) ? '0 : (in_tnew - TNEW_W'(1));

    // Pick the data source at capture time; loads keep the raw memory word
    always_comb begin
        w_src = in_mem_data;
        if (in_ld_op == c_OP_ALT) begin
            w_src = in_alt;
        end else if (in_ld_op == c_OP_NONE) begin
            w_src = in_result;
        end
    end

    // Pointers, occupancy and per-entry capture / Tnew countdown
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_count <= 2'd0;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_pc[i]   <= '0;
                r_rd[i]   <= '0;
                r_we[i]   <= 1'b0;
                r_op[i]   <= '0;
                r_data[i] <= '0;
                r_alo[i]  <= '0;
                r_tnew[i] <= '0;
            end
        end else begin
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            if (w_push) begin
                r_tail <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            for (int i = 0; i < 2; i++) begin
                if (w_push && (r_tail == i[0])) begin
                    r_pc[i]   <= in_pc;
                    r_rd[i]   <= in_rd;
                    r_we[i]   <= in_we;
                    r_op[i]   <= in_ld_op;
                    r_data[i] <= w_src;
                    r_alo[i]  <= in_addr_lo;
                    r_tnew[i] <= w_tnew_cap;
                end else if (r_tnew[i] != '0) begin
                    r_tnew[i] <= r_tnew[i] - TNEW_W'(1);
                end
            end
        end
    end

    // Head entry view
    logic [DATA_W-1:0] w_h_data;
    logic [LSB_W-1:0]  w_h_alo;
    logic [2:0]        w_h_op;
    logic [LSB_W+2:0]  w_b_amt;
    logic [LSB_W+2:0]  w_h_amt;
    logic [DATA_W-1:0] w_byte_sh;
    logic [DATA_W-1:0] w_half_sh;
    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] w_wdata;

    assign w_h_data  = r_data[r_head];
    assign w_h_alo   = r_alo[r_head];
    assign w_h_op    = r_op[r_head];

    // Byte lane is addr_lo; halfword lane ignores addr_lo[0]
    assign w_b_amt   = {w_h_alo, 3'b000};
    assign w_h_amt   = {w_h_alo[LSB_W-1:1], 4'b0000};
    assign w_byte_sh = w_h_data >> w_b_amt;
    assign w_half_sh = w_h_data >> w_h_amt;

    // Word loads: full word on 32-bit datapaths, sign-extended lane on 64-bit
    generate
        if (DATA_W == 64) begin : g_word64
            assign w_word = w_h_alo[LSB_W-1] ? {{32{w_h_data[63]}}, w_h_data[63:32]}
                                             : {{32{w_h_data[31]}}, w_h_data[31:0]};
        end else begin : g_word32
            assign w_word = w_h_data;
        end
    endgenerate

    // Writeback data formatting; ld, alt and none pass the stored value
    always_comb begin
        w_wdata = w_h_data;
        case (w_h_op)
            c_OP_LB:  w_wdata = {{(DATA_W-8){w_byte_sh[7]}}, w_byte_sh[7:0]};
            c_OP_LBU: w_wdata = {{(DATA_W-8){1'b0}}, w_byte_sh[7:0]};
            c_OP_LH:  w_wdata = {{(DATA_W-16){w_half_sh[15]}}, w_half_sh[15:0]};
            c_OP_LHU: w_wdata = {{(DATA_W-16){1'b0}}, w_half_sh[15:0]};
            c_OP_LW:  w_wdata = w_word;
            default:  w_wdata = w_h_data;
        endcase
    end

    // Outputs are forced to zero while the buffer is empty
    assign out_valid = w_valid;
    assign out_pc    = w_valid ? r_pc[r_head] : '0;
    assign out_rd    = w_valid ? r_rd[r_head] : '0;
    assign out_we    = w_valid & r_we[r_head] & (r_rd[r_head] != '0);
    assign out_wdata = w_valid ? w_wdata : '0;
    assign out_tnew  = w_valid ? r_tnew[r_head] : '0;

endmodule
`default_nettype wire
